preamble_burst_gate: RTL

PREAMBLE_BURST_GATE -- requirements
Module: preamble_burst_gate

---
 rtl/preamble_burst_gate.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/preamble_burst_gate.sv
// rtl/preamble_burst_gate.sv - gates a fixed-length burst of samples after each detection marker
// Burst/holdoff/ctrl are shadowed at the trigger so mid-burst settings writes only affect the next burst.
module preamble_burst_gate #(
  parameter int WIDTH   = 32,
  parameter int SR_BASE = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             busy
);
  localparam logic [7:0]       ADDR_LEN  = 8'(SR_BASE);
  localparam logic [7:0]       ADDR_HOLD = 8'(SR_BASE + 1);
  localparam logic [7:0]       ADDR_CTRL = 8'(SR_BASE + 2);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLDOFF, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] burst_len, holdoff, sh_len, sh_hold, beat_cnt, hold_cnt, len_eff;
  logic             enable, single_shot, sh_single;
  logic             wr_len, wr_hold, wr_ctrl, trig_cand, trigger, accepted, cap_last;
  logic             unused_bits;

  assign wr_len      = set_stb && (set_addr == ADDR_LEN);
  assign wr_hold     = set_stb && (set_addr == ADDR_HOLD);
  assign wr_ctrl     = set_stb && (set_addr == ADDR_CTRL);
  assign len_eff     = (burst_len == '0) ? ONE : burst_len;
  assign trig_cand   = (state == IDLE) && enable && i_tvalid && i_tlast;
  assign trigger     = trig_cand && o_tready;
  assign accepted    = i_tvalid && i_tready;
  assign cap_last    = (beat_cnt == sh_len - ONE);
  assign o_tdata     = i_tdata;
  assign busy        = (state == CAPTURE) || (state == HOLDOFF);
  assign unused_bits = ^set_data[31:CNT_W];

  function automatic state_t after_burst(input logic single, input logic [CNT_W-1:0] hold);
    if (single)          return DONE;
    else if (hold != '0) return HOLDOFF;
    else                 return IDLE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  // The trigger beat itself is forwarded, so IDLE must present it downstream combinationally.
  always_comb begin
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    i_tready = 1'b1;
    case (state)
      IDLE: begin
        if (trig_cand) begin
          o_tvalid = 1'b1;
          i_tready = o_tready;
          o_tlast  = (len_eff == ONE);
        end
      end
      CAPTURE: begin
        o_tvalid = i_tvalid;
        i_tready = o_tready;
        o_tlast  = i_tvalid && cap_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      burst_len   <= ONE;
      holdoff     <= '0;
      enable      <= 1'b0;
      single_shot <= 1'b0;
      sh_len      <= ONE;
      sh_hold     <= '0;
      sh_single   <= 1'b0;
      beat_cnt    <= '0;
      hold_cnt    <= '0;
      trig_count  <= '0;
      miss_count  <= '0;
    end else begin
      if (wr_len)  burst_len <= set_data[CNT_W-1:0];
      if (wr_hold) holdoff   <= set_data[CNT_W-1:0];
      if (wr_ctrl) begin
        enable      <= set_data[0];
        single_shot <= set_data[1];
      end
      if (clear) begin
        state      <= IDLE;
        beat_cnt   <= '0;
        hold_cnt   <= '0;
        trig_count <= '0;
        miss_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (trigger) begin
              sh_len     <= len_eff;
              sh_hold    <= holdoff;
              sh_single  <= single_shot;
              beat_cnt   <= ONE;
              hold_cnt   <= '0;
              trig_count <= sat_inc(trig_count);
              state      <= (len_eff == ONE) ? after_burst(single_shot, holdoff) : CAPTURE;
            end
          end
          CAPTURE: begin
            if (accepted) begin
              if (i_tlast) miss_count <= sat_inc(miss_count);
              beat_cnt <= beat_cnt + ONE;
              if (cap_last) begin
                state    <= after_burst(sh_single, sh_hold);
                hold_cnt <= '0;
              end
            end
          end
          HOLDOFF: begin
            if (accepted) begin
              if (i_tlast) miss_count <= sat_inc(miss_count);
              if (hold_cnt == sh_hold - ONE) state <= sh_single ? DONE : IDLE;
              else                           hold_cnt <= hold_cnt + ONE;
            end
          end
          DONE: begin
            if (wr_ctrl) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
